// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI/DVI TMDS encoder: symbol width, the four
// control tokens sent during blanking, and RGB565 field offsets.
package hdmi_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    // RGB565 layout {R[15:11], G[10:5], B[4:0]}
    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Control-token lookup for C = {c1, c0}
    function automatic logic [TMDS_W-1:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_TOKEN_00;
            2'b01:   return CTRL_TOKEN_01;
            2'b10:   return CTRL_TOKEN_10;
            default: return CTRL_TOKEN_11;
        endcase
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One DVI 1.0 TMDS channel: 8-bit data or 2-bit control in, 10-bit symbol out.
// Two register stages (transition-minimised q_m, then DC-balanced symbol),
// each channel keeps its own running disparity. DISP_W must be >= 5.
module tmds_channel_enc
    import hdmi_pkg::*;
#(
    parameter int DISP_W = 5
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              de_i,
    input  logic [1:0]        c_i,
    input  logic [7:0]        d_i,
    output logic [TMDS_W-1:0] tmds_o
);

    logic [3:0]               n1_d;
    logic                     use_xnor;
    logic [8:0]               q_m;
    logic                     de_s1;
    logic [1:0]               c_s1;
    logic [8:0]               q_m_s1;
    logic [3:0]               n1_q;
    logic [3:0]               n0_q;
    logic signed [DISP_W-1:0] n1_s;
    logic signed [DISP_W-1:0] n0_s;
    logic signed [DISP_W-1:0] two_q8;
    logic signed [DISP_W-1:0] two_nq8;
    logic                     cnt_pos;
    logic                     cnt_neg;
    logic signed [DISP_W-1:0] cnt;
    logic signed [DISP_W-1:0] cnt_nxt;
    logic [TMDS_W-1:0]        sym_nxt;

    assign n1_d     = 4'($countones(d_i));
    assign use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_i[0]);

    // Stage 1: XOR/XNOR chain that minimises transitions
    always_comb begin
        // NOTE: every variable gets a value before any branch/loop so no latch is inferred.
        q_m    = '0;
        q_m[0] = d_i[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d_i[i]) : (q_m[i-1] ^ d_i[i]);
        end
        q_m[8] = ~use_xnor;
    end

    // Stage 1 register: de, control bits and q_m
    always_ff @(posedge sys_clk_i) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge values together.
        if (rst_i) begin
            de_s1  <= 1'b0;
            c_s1   <= 2'b00;
            q_m_s1 <= '0;
        end else begin
            de_s1  <= de_i;
            c_s1   <= c_i;
            q_m_s1 <= q_m;
        end
    end

    assign n1_q    = 4'($countones(q_m_s1[7:0]));
    assign n0_q    = 4'd8 - n1_q;
    assign n1_s    = DISP_W'(n1_q);
    assign n0_s    = DISP_W'(n0_q);
    assign two_q8  = q_m_s1[8] ? DISP_W'(2) : '0;
    assign two_nq8 = q_m_s1[8] ? '0 : DISP_W'(2);
    assign cnt_neg = cnt[DISP_W-1];
    assign cnt_pos = !cnt[DISP_W-1] && (cnt != '0);

    // Stage 2: DC-balancing symbol selection and disparity update
    always_comb begin
        sym_nxt = ctrl_token(c_s1);
        cnt_nxt = '0;
        if (de_s1) begin
            if ((cnt == '0) || (n1_q == n0_q)) begin
                sym_nxt = {~q_m_s1[8], q_m_s1[8],
                           q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
                cnt_nxt = q_m_s1[8] ? (cnt + n1_s - n0_s) : (cnt + n0_s - n1_s);
            end else if ((cnt_pos && (n1_q > n0_q)) || (cnt_neg && (n0_q > n1_q))) begin
                sym_nxt = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
                cnt_nxt = cnt + two_q8 + n0_s - n1_s;
            end else begin
                sym_nxt = {1'b0, q_m_s1[8], q_m_s1[7:0]};
                cnt_nxt = cnt - two_nq8 + n1_s - n0_s;
            end
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            tmds_o <= CTRL_TOKEN_00;
            cnt    <= '0;
        end else begin
            tmds_o <= sym_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// HDMI/DVI TMDS encoder: RGB565 + sync + de in, three 10-bit symbols out,
// fixed 2-cycle latency. ch0 = blue (carries {vsync,hsync} in blanking),
// ch1 = green, ch2 = red.
// Build option RGB565_BIT_REPLICATE_EN: expand by replicating MSBs into the
// low bits (0xFFFF -> FF/FF/FF); otherwise zero-pad (0xFFFF -> F8/FC/F8).
module hdmi_tmds_encoder
    import hdmi_pkg::*;
#(
    parameter bit SYNC_INVERT = 1'b0,
    parameter int DISP_W      = 5
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [15:0]       rgb_i,
    output logic [TMDS_W-1:0] tmds_ch0_o,
    output logic [TMDS_W-1:0] tmds_ch1_o,
    output logic [TMDS_W-1:0] tmds_ch2_o
);

    logic       hs;
    logic       vs;
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    rgb888_t    px;

    assign hs = hsync_i ^ SYNC_INVERT;
    assign vs = vsync_i ^ SYNC_INVERT;
    assign r5 = rgb_i[R_LSB +: R_W];
    assign g6 = rgb_i[G_LSB +: G_W];
    assign b5 = rgb_i[B_LSB +: B_W];

`ifdef RGB565_BIT_REPLICATE_EN
    assign px = '{r: {r5, r5[4:2]}, g: {g6, g6[5:4]}, b: {b5, b5[4:2]}};
`else
    assign px = '{r: {r5, 3'b000}, g: {g6, 2'b00}, b: {b5, 3'b000}};
`endif

    tmds_channel_enc #(.DISP_W(DISP_W)) u_ch0 (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .de_i      (de_i),
        .c_i       ({vs, hs}),
        .d_i       (px.b),
        .tmds_o    (tmds_ch0_o)
    );

    tmds_channel_enc #(.DISP_W(DISP_W)) u_ch1 (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .de_i      (de_i),
        .c_i       (2'b00),
        .d_i       (px.g),
        .tmds_o    (tmds_ch1_o)
    );

    tmds_channel_enc #(.DISP_W(DISP_W)) u_ch2 (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .de_i      (de_i),
        .c_i       (2'b00),
        .d_i       (px.r),
        .tmds_o    (tmds_ch2_o)
    );

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: stimulus pushes expected symbols
// (or expected decoded bytes) tagged with the cycle they are due; a monitor
// pops and compares two cycles later.
module tb_hdmi_tmds_encoder;

    logic       sys_clk_i = 1'b0;
    logic       rst_i     = 1'b1;
    logic       de_i      = 1'b0;
    logic       hsync_i   = 1'b0;
    logic       vsync_i   = 1'b0;
    logic [15:0] rgb_i    = '0;
    logic [9:0] tmds_ch0_o;
    logic [9:0] tmds_ch1_o;
    logic [9:0] tmds_ch2_o;

    hdmi_tmds_encoder dut (
        .sys_clk_i  (sys_clk_i),
        .rst_i      (rst_i),
        .de_i       (de_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .rgb_i      (rgb_i),
        .tmds_ch0_o (tmds_ch0_o),
        .tmds_ch1_o (tmds_ch1_o),
        .tmds_ch2_o (tmds_ch2_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        int         due;
        bit         dec;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
        bit         chk_cnt;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Returns {r8, g8, b8}
    function automatic logic [23:0] expand(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
`ifdef RGB565_BIT_REPLICATE_EN
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
`else
        return {r, 3'b000, g, 2'b00, b, 3'b000};
`endif
    endfunction

    // Reference TMDS data-symbol decoder
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Monitor: compare every entry that falls due this cycle
    initial begin
        exp_t e;
        int   c0, c1, c2;
        forever begin
            @(posedge sys_clk_i);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("sb_due", 32'(cyc), 32'(e.due));
                c0 = int'($signed(dut.u_ch0.cnt));
                c1 = int'($signed(dut.u_ch1.cnt));
                c2 = int'($signed(dut.u_ch2.cnt));
                if (!e.dec) begin
                    check("ch0", 32'(tmds_ch0_o), 32'(e.e0));
                    check("ch1", 32'(tmds_ch1_o), 32'(e.e1));
                    check("ch2", 32'(tmds_ch2_o), 32'(e.e2));
                end else begin
                    check("dec_b", 32'(decode(tmds_ch0_o)), 32'(e.e0[7:0]));
                    check("dec_g", 32'(decode(tmds_ch1_o)), 32'(e.e1[7:0]));
                    check("dec_r", 32'(decode(tmds_ch2_o)), 32'(e.e2[7:0]));
                    check("disp_bound0", 32'(iabs(c0) <= 10), 32'd1);
                    check("disp_bound1", 32'(iabs(c1) <= 10), 32'd1);
                    check("disp_bound2", 32'(iabs(c2) <= 10), 32'd1);
                end
                if (e.chk_cnt) check("cnt0", 32'(c0), 32'(e.cnt));
            end
        end
    end

    task automatic drive(input logic de, input logic h, input logic v, input logic [15:0] rgb);
        @(negedge sys_clk_i);
        rst_i   = 1'b0;
        de_i    = de;
        hsync_i = h;
        vsync_i = v;
        rgb_i   = rgb;
    endtask

    task automatic vec(input logic [15:0] rgb, input logic [9:0] e0, input logic [9:0] e1,
                       input logic [9:0] e2, input int cnt);
        drive(1'b1, 1'b0, 1'b0, rgb);
        sb.push_back('{cyc + 2, 1'b0, e0, e1, e2, 1'b1, cnt});
    endtask

    task automatic vec_dec(input logic [15:0] rgb);
        logic [23:0] x;
        x = expand(rgb);
        drive(1'b1, 1'b0, 1'b0, rgb);
        sb.push_back('{cyc + 2, 1'b1, {2'b00, x[7:0]}, {2'b00, x[15:8]}, {2'b00, x[23:16]}, 1'b0, 0});
    endtask

    task automatic blank(input logic h, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, h, v, 16'hA5A5);
            sb.push_back('{cyc + 2, 1'b0, tok({v, h}), 10'h354, 10'h354, 1'b1, 0});
        end
    endtask

    // Reset flushes everything in flight; the cleared stage 1 yields one more 0x354
    task automatic do_rst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk_i);
            rst_i = 1'b1;
            de_i  = 1'b1;
            rgb_i = 16'h1234;
            sb.delete();
            sb.push_back('{cyc + 1, 1'b0, 10'h354, 10'h354, 10'h354, 1'b1, 0});
        end
        sb.push_back('{cyc + 2, 1'b0, 10'h354, 10'h354, 10'h354, 1'b1, 0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle blanking
        do_rst(2);
        blank(1'b0, 1'b0, 3);
        // Sync tokens on ch0
        blank(1'b1, 1'b0, 2);
        blank(1'b0, 1'b1, 1);
        blank(1'b1, 1'b1, 1);
        blank(1'b0, 1'b0, 2);
        // Black: exercises all three balancing branches
        vec(16'h0000, 10'h100, 10'h100, 10'h100, -8);
        vec(16'h0000, 10'h3FF, 10'h3FF, 10'h3FF, 2);
        vec(16'h0000, 10'h100, 10'h100, 10'h100, -6);
        blank(1'b0, 1'b0, 2);
        // White
`ifdef RGB565_BIT_REPLICATE_EN
        vec(16'hFFFF, 10'h200, 10'h200, 10'h200, -8);
        vec(16'hFFFF, 10'h0FF, 10'h0FF, 10'h0FF, -2);
        vec(16'hFFFF, 10'h0FF, 10'h0FF, 10'h0FF, 4);
`else
        vec(16'hFFFF, 10'h2FD, 10'h201, 10'h2FD, 6);
        vec(16'hFFFF, 10'h002, 10'h0FE, 10'h002, -2);
        vec(16'hFFFF, 10'h2FD, 10'h0FE, 10'h2FD, 4);
`endif
        // de toggling every cycle
        for (int i = 0; i < 8; i++) begin
            vec_dec(16'($urandom));
            blank(1'b0, 1'b0, 1);
        end
        // One full line: 1920 active, 280 blanking with an hsync pulse
        for (int i = 0; i < 1920; i++) vec_dec(16'($urandom));
        blank(1'b0, 1'b0, 88);
        blank(1'b1, 1'b0, 44);
        blank(1'b0, 1'b0, 148);
        // Mid-line reset, then resume
        for (int i = 0; i < 10; i++) vec_dec(16'($urandom));
        do_rst(1);
        vec(16'h0000, 10'h100, 10'h100, 10'h100, -8);
        for (int i = 0; i < 20; i++) vec_dec(16'($urandom));
        blank(1'b0, 1'b0, 2);
        // Drain, bounded
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
